// File: rtl/counter_if.sv
// Iteration-done flag from the multiplier's cycle counter.
// The counter drives it (master) and the control FSM samples it (slave).
interface counter_if;
  logic K;

  modport master (output K);
  modport slave  (input  K);
endinterface

// File: rtl/counter.sv
// Iteration counter for the shift-add multiplier control unit; K marks the N-th iteration.
// Latency: K rises on the (N-1)-th edge after Load is released. No backpressure; free-runs until Load.
module counter #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic      Clk,
  input  logic      Load,
  counter_if.master cnt
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  // Load doubles as the async reset, so it clears K without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Load) begin
    if (Load) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt.K = (count_q == LAST);

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter at N=4 and N=8: stimulus queues expected K, a monitor compares.
module tb_counter;

  typedef struct {
    string nm;
    bit    sel;
    logic  exp;
  } chk_t;

  logic Clk;
  logic load4;
  logic load8;
  int   checks;
  int   errors;
  chk_t q[$];
  event chk_ev;

  counter_if if4 ();
  counter_if if8 ();

  counter #(.N(4)) dut4 (.Clk(Clk), .Load(load4), .cnt(if4.master));
  counter #(.N(8)) dut8 (.Clk(Clk), .Load(load8), .cnt(if8.master));

  initial begin
    Clk = 1'b0;
    forever #40 Clk = ~Clk;
  end

  // Monitor: on every falling edge or an explicit mid-cycle request, drain and compare.
  initial begin
    chk_t c;
    logic act;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge Clk or chk_ev);
      while (q.size() > 0) begin
        c = q.pop_front();
        act = c.sel ? if8.K : if4.K;
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s N=%0d: K=%b, expected %b at %0t", c.nm, c.sel ? 8 : 4, act, c.exp, $time);
        end
      end
    end
  end

  task automatic push(input string nm, input bit sel, input logic exp);
    chk_t c;
    c.nm  = nm;
    c.sel = sel;
    c.exp = exp;
    q.push_back(c);
  endtask

  // One rising edge, then queue the expected K of both instances for the next falling edge.
  task automatic step(input string nm, input logic e4, input logic e8);
    @(posedge Clk);
    push(nm, 1'b0, e4);
    push(nm, 1'b1, e8);
  endtask

  initial begin
    load4 = 1'b0;
    load8 = 1'b0;
    #1;
    load4 = 1'b1;
    load8 = 1'b1;

    // Held in Load: clock edges must not advance either counter.
    for (int i = 0; i < 5; i++) step("load_hold", 1'b0, 1'b0);

    // Release N=4 on a falling edge and free-run 14 edges (period-4 pulse on edges 3,7,11).
    @(negedge Clk);
    load4 = 1'b0;
    for (int e = 1; e <= 14; e++) step("free_run", (e % 4) == 3, 1'b0);

    // Edge 15 raises K; Load mid-high-phase must drop it before any further edge.
    @(posedge Clk);
    #5;
    push("edge15_k", 1'b0, 1'b1);
    ->chk_ev;
    #10;
    load4 = 1'b1;
    #1;
    push("async_load", 1'b0, 1'b0);
    ->chk_ev;
    @(negedge Clk);
    load4 = 1'b0;
    step("after_async", 1'b0, 1'b0);
    step("after_async", 1'b0, 1'b0);
    step("after_async", 1'b1, 1'b0);
    step("after_async", 1'b0, 1'b0);

    // Load at count=2 for two edges, then restart from zero.
    step("mid_count", 1'b0, 1'b0);
    step("mid_count", 1'b0, 1'b0);
    @(negedge Clk);
    load4 = 1'b1;
    step("mid_load", 1'b0, 1'b0);
    step("mid_load", 1'b0, 1'b0);
    @(negedge Clk);
    load4 = 1'b0;
    step("restart", 1'b0, 1'b0);
    step("restart", 1'b0, 1'b0);
    step("restart", 1'b1, 1'b0);
    step("restart", 1'b0, 1'b0);

    // N=8: K only on edges 7 and 15, one cycle wide, with N=4 held in Load.
    @(negedge Clk);
    load4 = 1'b1;
    load8 = 1'b0;
    for (int e = 1; e <= 16; e++) step("n8_run", 1'b0, (e % 8) == 7);

    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
